// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a one-entry skid buffer. The branch outcome is
// resolved when an entry is accepted, and in_ready is driven from a register.
module ex_mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic [31:0] store_data,
    input  logic [31:0] br_target,
    input  logic [4:0]  rd_addr,
    input  logic [5:0]  ctrl_in,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_result,
    output logic [31:0] out_store_data,
    output logic [31:0] out_br_target,
    output logic [4:0]  out_rd_addr,
    output logic [3:0]  out_ctrl,
    output logic        br_taken
);

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [31:0] br_target;
        logic [4:0]  rd_addr;
        logic [3:0]  ctrl;
        logic        taken;
    } entry_t;

    // State encoding is {out_v, skid_v}; the illegal (0,1) pairing is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t r_state;
    entry_t r_out;
    entry_t r_skid;
    entry_t w_in;
    logic   w_accept;
    logic   w_pop;

    always_comb begin
        w_in.result     = alu_result;
        w_in.store_data = store_data;
        w_in.br_target  = br_target;
        w_in.rd_addr    = rd_addr;
        w_in.ctrl       = ctrl_in[5:2];
        // branch_inv flips the sense of the zero test (beq vs bne).
        w_in.taken      = ctrl_in[1] & (alu_zero ^ ctrl_in[0]);
    end

    assign in_ready = ~r_state[0];
    assign w_accept = in_valid & in_ready;
    assign w_pop    = r_state[1] & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_out   <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_out   <= w_in;
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        r_out <= w_in;
                    end else if (w_accept) begin
                        r_skid  <= w_in;
                        r_state <= FULL;
                    end else if (w_pop) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_out   <= r_skid;
                        r_state <= ONE;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign out_valid      = r_state[1];
    assign br_taken       = r_state[1] & r_out.taken;
    assign out_result     = r_out.result;
    assign out_store_data = r_out.store_data;
    assign out_br_target  = r_out.br_target;
    assign out_rd_addr    = r_out.rd_addr;
    assign out_ctrl       = r_out.ctrl;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: the stage is modelled as a 2-deep FIFO queue with
// flush/reset clearing it; directed scenarios pin the model with literal values.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [31:0] store_data;
    logic [31:0] br_target;
    logic [4:0]  rd_addr;
    logic [5:0]  ctrl_in;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic [31:0] out_br_target;
    logic [4:0]  out_rd_addr;
    logic [3:0]  out_ctrl;
    logic        br_taken;

    int n_chk  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    typedef struct {
        logic [31:0] r;
        logic [31:0] sd;
        logic [31:0] bt;
        logic [4:0]  rd;
        logic [3:0]  c;
        logic        t;
    } ent_t;

    ent_t q[$];

    ex_mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result     (alu_result),
        .alu_zero       (alu_zero),
        .store_data     (store_data),
        .br_target      (br_target),
        .rd_addr        (rd_addr),
        .ctrl_in        (ctrl_in),
        .flush          (flush),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_result     (out_result),
        .out_store_data (out_store_data),
        .out_br_target  (out_br_target),
        .out_rd_addr    (out_rd_addr),
        .out_ctrl       (out_ctrl),
        .br_taken       (br_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: compare on the falling edge, then advance using the inputs the DUT will sample.
    always @(negedge clk) begin
        if (chk_en) begin
            ent_t e;
            logic pop;
            logic acc;
            chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("m_in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() != 0) begin
                chk("m_result", out_result, q[0].r);
                chk("m_store", out_store_data, q[0].sd);
                chk("m_target", out_br_target, q[0].bt);
                chk("m_rd", 32'(out_rd_addr), 32'(q[0].rd));
                chk("m_ctrl", 32'(out_ctrl), 32'(q[0].c));
                chk("m_taken", 32'(br_taken), 32'(q[0].t));
            end else begin
                chk("m_taken_idle", 32'(br_taken), 32'd0);
            end
            if (flush) begin
                q.delete();
            end else begin
                pop = (q.size() != 0) && out_ready;
                acc = in_valid && (q.size() < 2);
                if (pop) void'(q.pop_front());
                if (acc) begin
                    e.r  = alu_result;
                    e.sd = store_data;
                    e.bt = br_target;
                    e.rd = rd_addr;
                    e.c  = ctrl_in[5:2];
                    e.t  = ctrl_in[1] && (alu_zero != ctrl_in[0]);
                    q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        in_valid   = 1'b1;
        alu_result = v;
        step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_br_taken"}, 32'(br_taken), 32'd0);
        chk({tag, "_result"}, out_result, 32'd0);
        chk({tag, "_store"}, out_store_data, 32'd0);
        chk({tag, "_target"}, out_br_target, 32'd0);
        chk({tag, "_rd"}, 32'(out_rd_addr), 32'd0);
        chk({tag, "_ctrl"}, 32'(out_ctrl), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        alu_result = '0;
        alu_zero   = 1'b0;
        store_data = '0;
        br_target  = '0;
        rd_addr    = '0;
        ctrl_in    = '0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        #3;
        chk_reset_outputs("rst");

        // Streaming straight out of reset: first entry accepted on the first edge.
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        chk_en    = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push(32'(i));
            chk("stream_result", out_result, 32'(i));
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain", 32'(out_valid), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        push(32'hA);
        chk("bp_a_result", out_result, 32'hA);
        chk("bp_a_ready", 32'(in_ready), 32'd1);
        push(32'hB);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_full_result", out_result, 32'hA);
        in_valid = 1'b0;
        step();
        chk("bp_hold_result", out_result, 32'hA);
        out_ready = 1'b1;
        step();
        chk("bp_b_result", out_result, 32'hB);
        chk("bp_b_valid", 32'(out_valid), 32'd1);
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Branch resolution
        alu_zero  = 1'b1;
        br_target = 32'h100;
        ctrl_in   = 6'b000010;
        push(32'h0);
        chk("br_eq_taken", 32'(br_taken), 32'd1);
        chk("br_eq_target", out_br_target, 32'h100);
        ctrl_in = 6'b000011;
        push(32'h0);
        chk("br_ne_taken", 32'(br_taken), 32'd0);
        ctrl_in = 6'b101100;
        rd_addr = 5'd17;
        push(32'h55);
        chk("ctrl_copy", 32'(out_ctrl), 32'hB);
        chk("rd_copy", 32'(out_rd_addr), 32'd17);
        in_valid = 1'b0;
        step();

        // Flush while FULL with a new entry offered
        out_ready = 1'b0;
        push(32'hC);
        push(32'hD);
        chk("fl_full_ready", 32'(in_ready), 32'd0);
        flush      = 1'b1;
        in_valid   = 1'b1;
        alu_result = 32'hEE;
        step();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        chk("fl_payload_kept", out_result, 32'hC);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("fl_no_ghost", 32'(out_valid), 32'd0);

        // Asynchronous reset between edges while FULL
        out_ready = 1'b0;
        br_target = 32'h1234;
        store_data = 32'h77;
        ctrl_in   = 6'b111110;
        push(32'h21);
        push(32'h22);
        in_valid = 1'b0;
        #1;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk_reset_outputs("arst");
        q.delete();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid   = ($urandom_range(0, 99) < 70);
            out_ready  = ($urandom_range(0, 99) < 65);
            flush      = ($urandom_range(0, 99) < 4);
            alu_result = $urandom;
            alu_zero   = 1'($urandom_range(0, 1));
            store_data = $urandom;
            br_target  = $urandom;
            rd_addr    = 5'($urandom);
            ctrl_in    = 6'($urandom);
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();
        chk("final_drain", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
